// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared encodings and default timing constants for the
// multiply/divide issue controller.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_MIN_LATENCY    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 40;
    localparam int DEF_CNT_W          = 6;

    localparam logic KIND_MULT = 1'b0;
    localparam logic KIND_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_cycle_counter.sv
// multdiv_cycle_counter: WIDTH-bit up-counter with synchronous clear and
// enable. With SATURATE set it parks at all-ones instead of wrapping.
module multdiv_cycle_counter
#(
    parameter int WIDTH    = 6,
    parameter bit SATURATE = 1'b0
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = SATURATE && (&r_count);

    // count up while enabled; clear and reset take priority
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issue/writeback controller in front of the multicycle
// multiplier and divider. Latches one mult/div, pulses the selected unit's
// start, stalls until its result is accepted (or a timeout aborts the op),
// then presents the result to writeback for one cycle.
// Optional build macro: MULTDIV_PERF_EN adds perf_busy_cycles / perf_ops.
//
// state | meaning
// IDLE  | waiting for issue_valid; stall follows issue_valid
// START | one-cycle ctrl_MULT/ctrl_DIV pulse, BUSY counter cleared
// BUSY  | waiting for selected resultRDY (masked below MIN_LATENCY) or timeout
// DONE  | wb_valid for one cycle, stall released
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MIN_LATENCY    = DEF_MIN_LATENCY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    output logic [31:0] unit_opA,
    output logic [31:0] unit_opB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] mult_result,
    input  logic        mult_exception,
    input  logic        mult_resultRDY,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    input  logic        div_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
`ifdef MULTDIV_PERF_EN
    ,
    output logic [31:0] perf_busy_cycles,
    output logic [31:0] perf_ops
`endif
);

    localparam logic [CNT_W-1:0] LP_MIN_LAT = CNT_W'(MIN_LATENCY);
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_rd;
    logic        r_kind;
    logic        r_ctrl_mult;
    logic        r_ctrl_div;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;

    logic [CNT_W-1:0] w_busy_cnt;
    logic             w_in_busy;
    logic             w_rdy_sel;
    logic [31:0]      w_res_sel;
    logic             w_exc_sel;
    logic             w_accept;
    logic             w_timeout;

    assign w_in_busy = (r_state == BUSY);

    // cleared outside BUSY so the first BUSY cycle always sees zero
    multdiv_cycle_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b0)
    ) u_busy_cnt (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (!w_in_busy),
        .i_enable (w_in_busy),
        .o_count  (w_busy_cnt)
    );

    // only the unit that was started is listened to
    assign w_rdy_sel = (r_kind == KIND_DIV) ? div_resultRDY  : mult_resultRDY;
    assign w_res_sel = (r_kind == KIND_DIV) ? div_result     : mult_result;
    assign w_exc_sel = (r_kind == KIND_DIV) ? div_exception  : mult_exception;

    // a ready still high from the previous op is filtered by the latency mask
    assign w_accept  = w_in_busy && w_rdy_sel && (w_busy_cnt >= LP_MIN_LAT);
    assign w_timeout = w_in_busy && (w_busy_cnt == LP_TIMEOUT);

    // sequencing FSM with registered start pulses and writeback outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rd        <= '0;
            r_kind      <= KIND_MULT;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_wb_exc    <= 1'b0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (issue_valid) begin
                        r_op_a      <= issue_opA;
                        r_op_b      <= issue_opB;
                        r_rd        <= issue_rd;
                        r_kind      <= issue_is_div;
                        r_ctrl_div  <= issue_is_div;
                        r_ctrl_mult <= !issue_is_div;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_state <= BUSY;
                end
                BUSY: begin
                    if (w_accept) begin
                        r_wb_data  <= w_res_sel;
                        r_wb_exc   <= w_exc_sel;
                        r_wb_rd    <= r_rd;
                        r_wb_valid <= 1'b1;
                        r_state    <= DONE;
                    end else if (w_timeout) begin
                        r_wb_data  <= '0;
                        r_wb_exc   <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_valid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    // the instruction still in execute is the one retiring now
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // stall must stop the pipeline in the same cycle an op is presented
    assign stall = (r_state == IDLE) ? issue_valid : (r_state != DONE);

    assign unit_opA     = r_op_a;
    assign unit_opB     = r_op_b;
    assign ctrl_MULT    = r_ctrl_mult;
    assign ctrl_DIV     = r_ctrl_div;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exception = r_wb_exc;

`ifdef MULTDIV_PERF_EN
    // occupancy counter: every cycle spent in START or BUSY
    multdiv_cycle_counter #(
        .WIDTH    (32),
        .SATURATE (1'b1)
    ) u_perf_busy (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (1'b0),
        .i_enable ((r_state == START) || w_in_busy),
        .o_count  (perf_busy_cycles)
    );

    // completed ops, timeouts included
    multdiv_cycle_counter #(
        .WIDTH    (32),
        .SATURATE (1'b1)
    ) u_perf_ops (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (1'b0),
        .i_enable (r_state == DONE),
        .o_count  (perf_ops)
    );
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed and randomized checks of multdiv_ctrl against an
// op-level model: an op retires at the first BUSY cycle j >= MIN_LATENCY whose
// selected ready is high, otherwise at j == TIMEOUT with data 0 / exception 1.
module tb_multdiv_ctrl;

    localparam int MIN_LAT = 2;
    localparam int TMO     = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_is_div = 1'b0;
    logic [31:0] issue_opA = '0;
    logic [31:0] issue_opB = '0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] unit_opA;
    logic [31:0] unit_opB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] mult_result = '0;
    logic        mult_exception = 1'b0;
    logic        mult_resultRDY = 1'b0;
    logic [31:0] div_result = '0;
    logic        div_exception = 1'b0;
    logic        div_resultRDY = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
`ifdef MULTDIV_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_ops;
    logic [31:0] exp_busy = '0;
    logic [31:0] exp_ops  = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    multdiv_ctrl #(
        .MIN_LATENCY    (MIN_LAT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_is_div   (issue_is_div),
        .issue_opA      (issue_opA),
        .issue_opB      (issue_opB),
        .issue_rd       (issue_rd),
        .unit_opA       (unit_opA),
        .unit_opB       (unit_opB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_resultRDY (mult_resultRDY),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .div_resultRDY  (div_resultRDY),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_exception   (wb_exception)
`ifdef MULTDIV_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_ops         (perf_ops)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":unit_opA"}, unit_opA, 32'h0);
        chk({tag, ":unit_opB"}, unit_opB, 32'h0);
        chk({tag, ":ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'h0);
        chk({tag, ":stall"}, 32'(stall), 32'h0);
        chk({tag, ":wb_valid"}, 32'(wb_valid), 32'h0);
        chk({tag, ":wb_rd"}, 32'(wb_rd), 32'h0);
        chk({tag, ":wb_data"}, wb_data, 32'h0);
        chk({tag, ":wb_exc"}, 32'(wb_exception), 32'h0);
    endtask

    // Called at a negedge while the DUT is idle. sched[j] is the selected
    // unit's ready during BUSY cycle j; the other unit gets random noise.
    task automatic run_op(input string name, input logic kind, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [TMO:0] sched, input logic [31:0] res, input logic exc);
        int          done_j;
        logic        accepted;
        logic [31:0] exp_data;
        logic        exp_exc;
        logic [31:0] s_res;
        logic        s_exc;

        done_j   = TMO;
        accepted = 1'b0;
        for (int j = MIN_LAT; j <= TMO; j++) begin
            if (sched[j] && !accepted) begin
                done_j   = j;
                accepted = 1'b1;
            end
        end
        exp_data = accepted ? res : 32'h0;
        exp_exc  = accepted ? exc : 1'b1;

        issue_valid  = 1'b1;
        issue_is_div = kind;
        issue_opA    = a;
        issue_opB    = b;
        issue_rd     = rd;
        #1;
        chk({name, ":stall_on_issue"}, 32'(stall), 32'h1);

        @(negedge clock);
        issue_valid  = 1'b0;
        issue_is_div = 1'($urandom);
        issue_opA    = $urandom;
        issue_opB    = $urandom;
        issue_rd     = 5'($urandom);
        chk({name, ":ctrl_DIV"}, 32'(ctrl_DIV), 32'(kind));
        chk({name, ":ctrl_MULT"}, 32'(ctrl_MULT), 32'(!kind));
        chk({name, ":unit_opA"}, unit_opA, a);
        chk({name, ":unit_opB"}, unit_opB, b);
        chk({name, ":stall_start"}, 32'(stall), 32'h1);

        @(negedge clock);
        for (int j = 0; j <= done_j; j++) begin
            chk({name, ":busy_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'h0);
            chk({name, ":busy_wb_valid"}, 32'(wb_valid), 32'h0);
            chk({name, ":busy_stall"}, 32'(stall), 32'h1);
            chk({name, ":busy_unit_opA"}, unit_opA, a);
            s_res = (sched[j] && j >= MIN_LAT) ? res : $urandom;
            s_exc = (sched[j] && j >= MIN_LAT) ? exc : 1'($urandom);
            if (kind) begin
                div_resultRDY  = sched[j];
                div_result     = s_res;
                div_exception  = s_exc;
                mult_resultRDY = 1'($urandom);
                mult_result    = $urandom;
                mult_exception = 1'($urandom);
            end else begin
                mult_resultRDY = sched[j];
                mult_result    = s_res;
                mult_exception = s_exc;
                div_resultRDY  = 1'($urandom);
                div_result     = $urandom;
                div_exception  = 1'($urandom);
            end
            @(negedge clock);
        end

        // DONE cycle: a fresh-looking issue here must be ignored
        issue_valid    = 1'b1;
        mult_resultRDY = 1'($urandom);
        div_resultRDY  = 1'($urandom);
        chk({name, ":wb_valid"}, 32'(wb_valid), 32'h1);
        chk({name, ":wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({name, ":wb_data"}, wb_data, exp_data);
        chk({name, ":wb_exc"}, 32'(wb_exception), 32'(exp_exc));
        chk({name, ":stall_done"}, 32'(stall), 32'h0);

        @(negedge clock);
        issue_valid    = 1'b0;
        mult_resultRDY = 1'b0;
        div_resultRDY  = 1'b0;
        #1;
        chk({name, ":idle_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'h0);
        chk({name, ":idle_stall"}, 32'(stall), 32'h0);
        chk({name, ":idle_wb_valid"}, 32'(wb_valid), 32'h0);
        chk({name, ":hold_wb_data"}, wb_data, exp_data);
        chk({name, ":hold_wb_rd"}, 32'(wb_rd), 32'(rd));
`ifdef MULTDIV_PERF_EN
        exp_busy = exp_busy + 32'(done_j + 2);
        exp_ops  = exp_ops + 32'd1;
        chk({name, ":perf_busy"}, perf_busy_cycles, exp_busy);
        chk({name, ":perf_ops"}, perf_ops, exp_ops);
`endif
    endtask

    initial begin
        logic [TMO:0] s;

        // reset state
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        chk("idle_no_issue_stall", 32'(stall), 32'h0);

        // div 100/7 ready at count 33
        s = '0; s[33] = 1'b1;
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 5'd5, s, 32'd14, 1'b0);

        // mult -3*4 ready at count 17, divider ready noise
        s = '0; s[17] = 1'b1;
        run_op("mult_neg", 1'b0, 32'hFFFF_FFFD, 32'd4, 5'd7, s, 32'hFFFF_FFF4, 1'b0);

        // divide by zero reports the unit exception
        s = '0; s[5] = 1'b1;
        run_op("div_by_0", 1'b1, 32'd9, 32'd0, 5'd9, s, 32'd0, 1'b1);

        // stale ready at counts 0-1 must not be accepted
        s = '0; s[0] = 1'b1; s[1] = 1'b1; s[33] = 1'b1;
        run_op("stale_rdy", 1'b1, 32'd50, 32'd5, 5'd11, s, 32'd10, 1'b0);

        // earliest acceptance
        s = '0; s[MIN_LAT] = 1'b1;
        run_op("min_lat", 1'b0, 32'd6, 32'd7, 5'd12, s, 32'd42, 1'b0);

        // no ready ever: timeout
        s = '0;
        run_op("timeout", 1'b1, 32'd1, 32'd1, 5'd13, s, 32'd0, 1'b0);

        // ready exactly at the timeout count: accept wins
        s = '0; s[TMO] = 1'b1;
        run_op("accept_at_tmo", 1'b0, 32'd3, 32'd3, 5'd14, s, 32'hDEAD_BEEF, 1'b0);

        // rd == 0 still produces a writeback strobe
        s = '0; s[4] = 1'b1;
        run_op("rd_zero", 1'b0, 32'd2, 32'd2, 5'd0, s, 32'd4, 1'b0);

        // reset at BUSY count 10 abandons the op
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_opA    = 32'h1234_5678;
        issue_opB    = 32'h0000_0010;
        issue_rd     = 5'd3;
        @(negedge clock);
        issue_valid  = 1'b0;
        @(negedge clock);
        repeat (10) @(negedge clock);
        reset          = 1'b1;
        mult_resultRDY = 1'b1;
        mult_result    = 32'hAAAA_5555;
        @(negedge clock);
        chk_all_zero("mid_reset");
        reset         = 1'b0;
        div_resultRDY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("post_reset_wb_valid", 32'(wb_valid), 32'h0);
            chk("post_reset_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'h0);
            chk("post_reset_stall", 32'(stall), 32'h0);
        end
        mult_resultRDY = 1'b0;
        div_resultRDY  = 1'b0;
`ifdef MULTDIV_PERF_EN
        exp_busy = '0;
        exp_ops  = '0;
        chk("post_reset_perf_busy", perf_busy_cycles, 32'h0);
        chk("post_reset_perf_ops", perf_ops, 32'h0);
`endif
        s = '0; s[8] = 1'b1;
        run_op("after_reset", 1'b0, 32'd11, 32'd12, 5'd21, s, 32'd132, 1'b0);

        // randomized ops, including back-to-back issue after one idle cycle
        for (int n = 0; n < 20; n++) begin
            s = '0;
            for (int j = 0; j <= TMO; j++) s[j] = ($urandom_range(0, 15) == 0);
            run_op("rand", 1'($urandom), $urandom, $urandom, 5'($urandom),
                   s, $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Issue/writeback controller that sits directly upstream of the multicycle multiplier and divider units.
- Captures a mult/div instruction from the execute stage and latches its operands and destination register.
- Fires a one-cycle ctrl_MULT/ctrl_DIV start pulse and stalls the pipeline until the selected unit's resultRDY is accepted.
- Presents the result, destination and exception for one cycle to writeback.
- Guards against stale ready flags and hung units.

Parameters:
- MIN_LATENCY, 2: BUSY cycles during which unit resultRDY is masked (stale-ready filter).
- TIMEOUT_CYCLES, 40: BUSY cycle count at which the op is aborted with an exception.
- CNT_W, 6: counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  execute stage presents a mult/div
- issue_is_div  in  1  1=div, 0=mult
- issue_opA  in  32  operand A
- issue_opB  in  32  operand B
- issue_rd  in  5  destination register
- unit_opA  out  32  registered operand A to both units
- unit_opB  out  32  registered operand B to both units
- ctrl_MULT  out  1  start pulse to multiplier
- ctrl_DIV  out  1  start pulse to divider
- mult_result  in  32  multiplier result
- mult_exception  in  1  multiplier exception
- mult_resultRDY  in  1  multiplier done
- div_result  in  32  divider result
- div_exception  in  1  divider exception
- div_resultRDY  in  1  divider done
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  5  writeback destination
- wb_data  out  32  writeback data
- wb_exception  out  1  exception flag for writeback (drives rstatus update)

Behaviour:
- Reset (sync, active-high): state=IDLE, counter=0, all outputs 0 (unit_opA/B, wb_rd, wb_data included). Reset mid-op abandons the op: no wb_valid, and any later unit RDY is ignored.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - stall = issue_valid (combinational, same cycle).
  - On issue_valid: latch opA/opB into unit_opA/B, latch rd and kind; go START.
- START (1 cycle):
  - ctrl_DIV = kind, ctrl_MULT = ~kind; exactly one is high for exactly this cycle.
  - unit_opA/B are already stable this cycle and held until the next issue.
  - counter := 0; stall=1; go BUSY.
- BUSY:
  - stall=1; counter increments each cycle.
  - rdy_sel = kind ? div_resultRDY : mult_resultRDY. Accepted only when counter >= MIN_LATENCY.
  - On accept: capture the selected result into wb_data and the selected exception into wb_exception; go DONE.
  - Else if counter == TIMEOUT_CYCLES: wb_data=0, wb_exception=1; go DONE.
  - If accept and timeout occur in the same cycle, accept wins.
  - The non-selected unit's RDY/result are ignored.
- DONE (1 cycle):
  - wb_valid=1, wb_rd=latched rd, stall=0; go IDLE.
  - issue_valid is ignored in DONE (it is the same instruction leaving execute).
  - wb_data/wb_exception/wb_rd hold their values after DONE; only wb_valid drops.
- Latency: issue at cycle T → ctrl pulse at T+1 → earliest wb_valid at T+2+MIN_LATENCY+1. Minimum back-to-back issue period is latency+1 (one IDLE cycle).
- rd==0: wb_valid still pulses; regfile discards the write.

Optional Feature:
MULTDIV_PERF_EN
- Defined: adds outputs perf_busy_cycles (32) and perf_ops (32).
  - perf_busy_cycles increments every cycle in START or BUSY.
  - perf_ops increments on every DONE, including timeouts.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package multdiv_pkg: state encoding (IDLE=0, START=1, BUSY=2, DONE=3), default MIN_LATENCY/TIMEOUT_CYCLES constants, kind encoding (KIND_MULT=0, KIND_DIV=1).
- Sub-module multdiv_cycle_counter: CNT_W up-counter with sync clear and enable, used for the BUSY counter. Perf counters reuse it at width 32 with saturation.

Test Plan:
- Div 100/7, rd=5, div_resultRDY raised at BUSY count 33 with div_result=14 → single ctrl_DIV pulse, ctrl_MULT never; stall high through BUSY; wb_valid one cycle with wb_rd=5, wb_data=14, wb_exception=0.
- Mult -3*4, rd=7, mult_resultRDY at count 17 with result 0xFFFFFFF4 → wb_data=0xFFFFFFF4, wb_rd=7; div_resultRDY toggling during the op is ignored.
- Div by 0 with div_exception=1, result 0 → wb_exception=1, wb_data=0, wb_valid one cycle.
- div_resultRDY held high from a prior op at counts 0–1, real RDY at count 33 → no early accept; writeback at count 33 only.
- No RDY ever, TIMEOUT_CYCLES=40 → DONE after counter==40; wb_exception=1, wb_data=0; stall drops.
- Reset asserted at BUSY count 10, then new mult issued → all outputs 0 the cycle after reset; no wb_valid for the aborted op; new op completes normally.
